// File: rtl/stone_pkg.sv
// Shared stone-record layout, type codes and sprite geometry for the stone RAM users.
package stone_pkg;

  localparam int X_MSB    = 31;
  localparam int X_LSB    = 23;
  localparam int Y_MSB    = 18;
  localparam int Y_LSB    = 11;
  localparam int TYPE_MSB = 3;
  localparam int TYPE_LSB = 2;
  localparam int VIS_BIT  = 1;
  localparam int MOV_BIT  = 0;

  localparam logic [1:0] TYPE_STONE   = 2'b00;
  localparam logic [1:0] TYPE_GOLD    = 2'b01;
  localparam logic [1:0] TYPE_DIAMOND = 2'b10;

  localparam logic [2:0] COL_STONE   = 3'b110;
  localparam logic [2:0] COL_GOLD    = 3'b111;
  localparam logic [2:0] COL_DIAMOND = 3'b011;

  localparam int SPRITE = 16;
  localparam int SPR_W  = $clog2(SPRITE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_LATCH,
    S_PLOT,
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/stone_colour_lut.sv
// Maps a stone record type code to its sprite colour.
module stone_colour_lut
  import stone_pkg::*;
(
  input  logic [1:0] type_i,
  output logic [2:0] colour_o
);

  always_comb begin
    colour_o = COL_DIAMOND;
    case (type_i)
      TYPE_STONE:   colour_o = COL_STONE;
      TYPE_GOLD:    colour_o = COL_GOLD;
      TYPE_DIAMOND: colour_o = COL_DIAMOND;
      default:      colour_o = COL_DIAMOND;
    endcase
  end

endmodule

// File: rtl/stone_drawer.sv
// Once-per-frame walk of the stone records, plotting a SPRITE x SPRITE block per visible stone.
// IDLE wait start | ADDR drive index | WAIT ram latency | LATCH take record | PLOT pixels | NEXT advance | DONE pulse done
module stone_drawer
  import stone_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  quantity,
  input  logic [31:0] q,
  output logic        draw_stone_flag,
  output logic [3:0]  draw_index,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        done
);

  state_e           state_q, state_d;
  logic [3:0]       qty_q, qty_d;
  logic [4:0]       idx_q, idx_d;
  logic [8:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [SPR_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic             flag_q, flag_d;
  logic [3:0]       index_q, index_d;
  logic [8:0]       vga_x_q, vga_x_d;
  logic [7:0]       vga_y_q, vga_y_d;
  logic [2:0]       colour_q, colour_d;
  logic             plot_q, plot_d;
  logic             done_q, done_d;

  logic [2:0]       lut_colour;
  logic [9:0]       sum_x, sum_y;
  logic             unused_q_bits;

  stone_colour_lut u_lut (
    .type_i   (q[TYPE_MSB:TYPE_LSB]),
    .colour_o (lut_colour)
  );

  // Ten-bit sums so sprites near the right/bottom edge are clipped, never wrapped.
  assign sum_x = 10'(x_q) + 10'(dx_q);
  assign sum_y = 10'(y_q) + 10'(dy_q);

  assign unused_q_bits = &{1'b0, q[X_LSB-1:Y_MSB+1], q[Y_LSB-1:TYPE_MSB+1], q[MOV_BIT]};

  always_comb begin
    state_d  = state_q;
    qty_d    = qty_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    flag_d   = flag_q;
    index_d  = index_q;
    vga_x_d  = vga_x_q;
    vga_y_d  = vga_y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          qty_d   = quantity;
          idx_d   = 5'd1;
          flag_d  = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (idx_q >= {1'b0, qty_q}) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          index_d = idx_q[3:0];
          state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = S_LATCH;
      S_LATCH: begin
        x_d      = q[X_MSB:X_LSB];
        y_d      = q[Y_MSB:Y_LSB];
        colour_d = lut_colour;
        dx_d     = '0;
        dy_d     = '0;
        state_d  = q[VIS_BIT] ? S_PLOT : S_NEXT;
      end
      S_PLOT: begin
        vga_x_d = sum_x[8:0];
        vga_y_d = sum_y[7:0];
        plot_d  = (sum_x < 10'(SCREEN_W)) && (sum_y < 10'(SCREEN_H));
        dx_d    = dx_q + SPR_W'(1);
        if (&dx_q) begin
          dy_d = dy_q + SPR_W'(1);
          if (&dy_q) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        idx_d   = idx_q + 5'd1;
        state_d = S_ADDR;
      end
      S_DONE: begin
        flag_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      qty_q    <= '0;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      flag_q   <= 1'b0;
      index_q  <= '0;
      vga_x_q  <= '0;
      vga_y_q  <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      qty_q    <= qty_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      flag_q   <= flag_d;
      index_q  <= index_d;
      vga_x_q  <= vga_x_d;
      vga_y_q  <= vga_y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign draw_stone_flag = flag_q;
  assign draw_index      = index_q;
  assign vga_x           = vga_x_q;
  assign vga_y           = vga_y_q;
  assign colour          = colour_q;
  assign plot            = plot_q;
  assign done            = done_q;

endmodule

// File: tb/tb_stone_drawer.sv
// Directed bench for stone_drawer: table of single/two-record passes plus reset, re-start and full-RAM sequences.
module tb_stone_drawer;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  quantity = 4'd0;
  logic [31:0] q;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  colour;
  logic        plot;
  logic        done;

  stone_drawer dut (
    .clock           (clock),
    .resetn          (resetn),
    .start           (start),
    .quantity        (quantity),
    .q               (q),
    .draw_stone_flag (draw_stone_flag),
    .draw_index      (draw_index),
    .vga_x           (vga_x),
    .vga_y           (vga_y),
    .colour          (colour),
    .plot            (plot),
    .done            (done)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM: address registered on the clock, data read from the registered address.
  logic [31:0] mem [16];
  logic [3:0]  ram_addr = 4'd0;
  always @(posedge clock) ram_addr <= draw_index;
  assign q = mem[ram_addr];

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } px_t;

  typedef struct {
    int qty; int x; int y; int typ; int vis; int r2vis;
    int plots; int flagc; int col; int fx; int fy; int lx; int ly; int lat;
  } vec_t;

  px_t act_q[$];
  px_t exp_q[$];
  int  idx_log[$];
  int  vec_cnt = 0, err_cnt = 0;
  int  cyc = 0, start_cyc = 0, first_cyc = -1;
  int  flag_cnt = 0, done_cnt = 0, done_bad = 0, last_idx = 0;
  int  timed_out = 0, post_flag = 0;
  bit  mon_en = 1'b0;
  vec_t vt[8];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mon_en) begin
      if (plot) begin
        if (act_q.size() == 0) first_cyc = cyc;
        act_q.push_back({vga_x, vga_y, colour});
      end
      if (draw_stone_flag) flag_cnt++;
      if (done) begin
        done_cnt++;
        if (!draw_stone_flag) done_bad++;
      end
      if (draw_stone_flag && int'(draw_index) != last_idx) begin
        idx_log.push_back(int'(draw_index));
        last_idx = int'(draw_index);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_rec(input int x, input int y, input int t, input int v);
    logic [8:0] xs; logic [7:0] ys; logic [1:0] ts; logic vs;
    xs = 9'(x); ys = 8'(y); ts = 2'(t); vs = (v != 0);
    return {xs, 4'hF, ys, 7'h7F, ts, vs, 1'b1};
  endfunction

  task automatic fill_junk();
    for (int k = 0; k < 16; k++) mem[k] = mk_rec(40, 40, 0, 1);
  endtask

  task automatic load_vec(input vec_t v);
    fill_junk();
    mem[1] = mk_rec(v.x, v.y, v.typ, v.vis);
    mem[2] = mk_rec(200, 100, 0, v.r2vis);
  endtask

  task automatic build_exp(input int qty);
    logic [31:0] r;
    int xi, yi;
    logic [2:0] c;
    exp_q.delete();
    for (int i = 1; i < qty; i++) begin
      r  = mem[i];
      xi = int'(r[31:23]);
      yi = int'(r[18:11]);
      c  = (r[3:2] == 2'b00) ? 3'b110 : (r[3:2] == 2'b01) ? 3'b111 : 3'b011;
      if (r[1]) begin
        for (int dy = 0; dy < 16; dy++)
          for (int dx = 0; dx < 16; dx++)
            if (xi + dx < 320 && yi + dy < 240)
              exp_q.push_back({9'(xi + dx), 8'(yi + dy), c});
      end
    end
  endtask

  function automatic int px_mism();
    int m, n;
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    m = (act_q.size() > exp_q.size()) ? act_q.size() - exp_q.size() : exp_q.size() - act_q.size();
    for (int i = 0; i < n; i++) if (act_q[i] != exp_q[i]) m++;
    return m;
  endfunction

  task automatic clear_mon();
    act_q.delete(); idx_log.delete();
    flag_cnt = 0; done_cnt = 0; done_bad = 0; first_cyc = -1;
  endtask

  task automatic run_pass(input int qty_v);
    int n;
    clear_mon();
    timed_out = 0;
    @(negedge clock);
    last_idx  = int'(draw_index);
    quantity  = 4'(qty_v);
    start     = 1'b1;
    start_cyc = cyc;
    mon_en    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 6000) begin
      @(negedge clock); #1;
      n++;
    end
    timed_out = (done_cnt == 0) ? 1 : 0;
    @(negedge clock); #1;
    post_flag = int'(draw_stone_flag);
    mon_en = 1'b0;
  endtask

  task automatic check_pass(input string nm, input int plots, input int flagc);
    chk({nm, "_timeout"}, timed_out, 0);
    chk({nm, "_plots"}, act_q.size(), plots);
    chk({nm, "_flag_cycles"}, flag_cnt, flagc);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_done_outside_flag"}, done_bad, 0);
    chk({nm, "_flag_after_done"}, post_flag, 0);
    chk({nm, "_pixel_seq"}, px_mism(), 0);
  endtask

  initial begin
    #3 resetn = 1'b0;
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_flag", int'(draw_stone_flag), 0);
    chk("rst_index", int'(draw_index), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    chk("rst_colour", int'(colour), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    //        qty  x   y  typ vis r2v plots flag col  fx  fy  lx  ly lat
    vt[0] = '{3, 100, 50, 1, 1, 0, 256, 266, 7, 100, 50, 115, 65, 4};
    vt[1] = '{2, 310, 230, 2, 1, 0, 100, 262, 3, 310, 230, 319, 239, 4};
    vt[2] = '{1, 100, 50, 1, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0};
    vt[3] = '{0, 100, 50, 1, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0};
    vt[4] = '{2, 0, 0, 0, 1, 0, 256, 262, 6, 0, 0, 15, 15, 4};
    vt[5] = '{2, 305, 224, 3, 1, 0, 240, 262, 3, 305, 224, 319, 239, 4};
    vt[6] = '{2, 500, 10, 1, 1, 0, 0, 262, 0, 0, 0, 0, 0, 0};
    vt[7] = '{3, 100, 50, 1, 0, 1, 256, 266, 6, 200, 100, 215, 115, 8};

    for (int i = 0; i < 8; i++) begin
      load_vec(vt[i]);
      build_exp(vt[i].qty);
      run_pass(vt[i].qty);
      check_pass($sformatf("v%0d", i), vt[i].plots, vt[i].flagc);
      if (vt[i].plots > 0 && act_q.size() > 0) begin
        chk($sformatf("v%0d_colour", i), int'(act_q[0].c), vt[i].col);
        chk($sformatf("v%0d_first_x", i), int'(act_q[0].x), vt[i].fx);
        chk($sformatf("v%0d_first_y", i), int'(act_q[0].y), vt[i].fy);
        chk($sformatf("v%0d_last_x", i), int'(act_q[act_q.size()-1].x), vt[i].lx);
        chk($sformatf("v%0d_last_y", i), int'(act_q[act_q.size()-1].y), vt[i].ly);
        chk($sformatf("v%0d_latency", i), first_cyc - start_cyc - 1, vt[i].lat);
      end
    end

    // Second start pulse in the middle of the sprite must be ignored.
    load_vec(vt[0]);
    build_exp(3);
    fork
      run_pass(3);
      begin
        repeat (60) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    join
    check_pass("restart", 256, 266);
    repeat (5) @(negedge clock);
    chk("restart_idle_flag", int'(draw_stone_flag), 0);

    // Asynchronous reset on the 100th pixel, then idle, then a clean pass.
    begin
      int n;
      load_vec(vt[0]);
      build_exp(3);
      clear_mon();
      @(negedge clock);
      last_idx = int'(draw_index);
      quantity = 4'd3;
      start = 1'b1;
      mon_en = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (act_q.size() < 100 && n < 2000) begin
        @(negedge clock); #1;
        n++;
      end
      chk("midrst_reached_px100", act_q.size(), 100);
      chk("midrst_plot_before", int'(plot), 1);
      resetn = 1'b0;
      #1;
      chk("midrst_plot", int'(plot), 0);
      chk("midrst_flag", int'(draw_stone_flag), 0);
      chk("midrst_index", int'(draw_index), 0);
      chk("midrst_vga_x", int'(vga_x), 0);
      mon_en = 1'b0;
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      clear_mon();
      mon_en = 1'b1;
      repeat (20) @(negedge clock);
      #1;
      mon_en = 1'b0;
      chk("postrst_idle_plots", act_q.size(), 0);
      chk("postrst_idle_flag", flag_cnt, 0);
      chk("postrst_idle_done", done_cnt, 0);
      run_pass(3);
      check_pass("postrst", 256, 266);
    end

    // Full RAM: indices 1..14 visible, index 0 and 15 hold visible decoys.
    fill_junk();
    for (int k = 1; k < 15; k++) mem[k] = mk_rec(16 * k, 8 * k, k % 4, 1);
    build_exp(15);
    run_pass(15);
    check_pass("qty15", 3584, 3642);
    chk("qty15_index_count", idx_log.size(), 14);
    for (int k = 0; k < 14; k++)
      chk($sformatf("qty15_index%0d", k),
          (k < idx_log.size()) ? idx_log[k] : 99, k + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/stone_drawer.md
Name: stone_drawer

Overview:
- Read side of the stone-record RAM interface. Once per frame it owns the RAM read address, walks the stone records, and emits one plot strobe per pixel of a 16x16 sprite for each visible stone.
- Sits between the stone RAM read port and the VGA adapter. The rope controller pauses its frame-timed updates while draw_stone_flag is high and uses draw_index as the RAM address during that time.

Parameters:
- SCREEN_W, 320, visible width; pixels with x >= SCREEN_W are suppressed.
- SCREEN_H, 240, visible height; pixels with y >= SCREEN_H are suppressed.
- SPRITE, 16, sprite edge length in pixels; must be a power of two.
- COL_STONE, 3'b110, colour for type 2'b00.
- COL_GOLD, 3'b111, colour for type 2'b01.
- COL_DIAMOND, 3'b011, colour for types 2'b10 and 2'b11.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that requests a frame redraw
- quantity  in  4  number of RAM slots in use; valid records are indices 1..quantity-1
- q  in  32  RAM read data; valid one cycle after the address is registered by the RAM
- draw_stone_flag  out  1  high while this block owns the RAM address
- draw_index  out  4  RAM read address
- vga_x  out  9  pixel x coordinate
- vga_y  out  8  pixel y coordinate
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- done  out  1  one-cycle pulse when the pass ends

Behaviour:
- Reset is asynchronous and active-low, applied to every register. All outputs reset to 0. State resets to S_IDLE.
- Record format:
  - x = q[31:23]
  - y = q[18:11]
  - type = q[3:2]
  - visible = q[1]
  - moving = q[0], which is ignored here.
- Index 0 is reserved and never read.
- States:
  - S_IDLE: flag=0. On start, latch quantity into qty_r, set idx=1, set flag=1, go to S_ADDR. start in any other state is ignored.
  - S_ADDR: if idx >= qty_r, go to S_DONE. Otherwise drive draw_index=idx and go to S_WAIT.
  - S_WAIT: one cycle of RAM latency.
  - S_LATCH: register x, y and colour from q, clear the pixel counters dx and dy. If visible=1, go to S_PLOT; otherwise go to S_NEXT.
  - S_PLOT: each cycle, set vga_x=x+dx and vga_y=y+dy; these are registered outputs.
    - plot=1 unless x+dx >= SCREEN_W or y+dy >= SCREEN_H. The comparison uses 10-bit sums, so there is no wrap-around.
    - dx increments; when dx wraps, dy increments. After pixel (15,15), go to S_NEXT.
    - Exactly 256 cycles per visible record.
  - S_NEXT: plot=0, idx=idx+1, go to S_ADDR.
  - S_DONE: flag=0, done=1 for one cycle, go to S_IDLE.
- Latency: the first pixel of record 1 appears 4 cycles after start is sampled. Each visible record costs 260 cycles and each invisible record costs 4.
- draw_index holds its last value when the flag is low and is stable for the whole record.
- quantity of 0 or 1: the flag is high for exactly 2 cycles (S_ADDR and S_DONE), then done pulses. No plot is produced.
- idx is 5 bits internally so that quantity=15 terminates correctly after index 14.
- Colour is decoded from type at S_LATCH and held for the whole sprite.
- Reset mid-pass: everything clears immediately. Flag and plot go low asynchronously; no partial resume.
- q is sampled only in S_LATCH. Changes to quantity after start have no effect until the next start.

Decomposition:
- Shared package stone_pkg:
  - record field bit positions: X_MSB=31, X_LSB=23, Y_MSB=18, Y_LSB=11, TYPE_MSB=3, TYPE_LSB=2, VIS_BIT=1, MOV_BIT=0
  - type codes TYPE_STONE=2'b00, TYPE_GOLD=2'b01, TYPE_DIAMOND=2'b10
  - SPRITE size
- Both the rope controller and this block use the package.
- One sub-module is natural: stone_colour_lut, a combinational mapping from type to colour.
- The FSM, address counter and pixel counter stay in stone_drawer.

Test Plan:
- quantity=3; record 1: x=100, y=50, type=01, visible=1; record 2: visible=0 -> 256 plots from (100,50) to (115,65) in row-major order, colour 3'b111. No plot for record 2. done pulses, and the flag is high from the cycle after start through S_DONE.
- quantity=2; record 1: x=310, y=230, type=10, visible=1 -> 256 S_PLOT cycles, but plot=1 only for x 310..319 and y 230..239 (100 pixels), colour 3'b011.
- quantity=1, start -> flag high for 2 cycles, zero plots, done one cycle after the flag falls low... specifically, done is asserted in the last flag-high cycle (S_DONE), and the flag is 0 the following cycle.
- Pulse start again during S_PLOT of record 1 -> ignored. Pixel sequence and total pass length are unchanged, and there is only one done pulse.
- Assert resetn=0 during the 100th pixel -> plot, flag and draw_index go to 0 immediately. After release, nothing happens until the next start; a full pass then completes correctly.
- quantity=15 with all records visible -> indices 1..14 are each read once, 14×256 = 3584 plot cycles, and the pass terminates without reading index 15 or index 0.
